// File: rtl/apb_requester.sv
// Single-outstanding APB initiator: core load/store to APB SETUP/ACCESS.
// Optional ACCESS-phase timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        r_state;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_abort;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

  logic [7:0] r_wait;

  // Counts ACCESS cycles spent waiting; cleared while in SETUP.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_wait <= 8'd0;
    end else if (r_state == S_SETUP) begin
      r_wait <= 8'd0;
    end else if (r_state == S_ACCESS && !pready) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  assign w_abort = (r_state == S_ACCESS) && !pready
                && (r_wait == TO_LIM);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state     <= S_IDLE;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= pslverr;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
          end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign psel      = (r_state != S_IDLE);
  assign penable   = (r_state == S_ACCESS);
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: scoreboard of expected responses plus
// cycle-accurate timing checks per scenario.
module tb_apb_requester;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        pclk;
  logic        preset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic        corrupt;
  logic [31:0] mem [16];
  exp_t        q[$];
  int          n_vec;
  int          n_err;

  apb_requester #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Simple memory slave; reset loads mem[i] = i + 1
  always @(posedge pclk) begin
    if (!preset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(i + 1);
    end else if (psel && penable && pready && pwrite) begin
      mem[paddr[5:2]] <= pwdata;
    end
  end

  assign prdata = corrupt ? 32'hDEAD_BEEF : mem[paddr[5:2]];

  // Response scoreboard, sampled on the falling edge
  always @(negedge pclk) begin
    if (rsp_valid) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, required none",
                 rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
          n_err++;
          $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                   rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    preset_n = 1'b0;
    tick;
    tick;
    n_vec++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata,
         rsp_err, req_ready} !== {3'b000, 64'd0, 1'b0, 32'd0, 2'b01}) begin
      n_err++;
      $display("FAIL reset: got psel=%b pen=%b pw=%b pa=%h pwd=%h rv=%b rd=%h re=%b rr=%b",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata,
               rsp_err, req_ready);
    end
    preset_n = 1'b1;
    tick;
  endtask

  task automatic test_write_zero_wait;
    pready    = 1'b1;
    pslverr   = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h4;
    req_wdata = 32'hB1;
    q.push_back({32'h0, 1'b0});
    tick;
    req_valid = 1'b0;
    n_vec++;
    if ({psel, penable, req_ready, pwrite, paddr, pwdata}
        !== {4'b1001, 32'h4, 32'hB1}) begin
      n_err++;
      $display("FAIL wr_setup: got sel=%b en=%b rr=%b pw=%b pa=%h pwd=%h, required 1 0 0 1 4 b1",
               psel, penable, req_ready, pwrite, paddr, pwdata);
    end
    tick;
    n_vec++;
    if ({psel, penable, paddr, pwdata} !== {2'b11, 32'h4, 32'hB1}) begin
      n_err++;
      $display("FAIL wr_access: got sel=%b en=%b pa=%h pwd=%h, required 1 1 4 b1",
               psel, penable, paddr, pwdata);
    end
    tick;
    n_vec++;
    if ({rsp_valid, psel, penable, req_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL wr_rsp_cycle3: got rv=%b sel=%b en=%b rr=%b, required 1 0 0 1",
               rsp_valid, psel, penable, req_ready);
    end
    req_addr  = 32'h30;
    req_wdata = 32'hFFFF;
    tick;
    n_vec++;
    if ({rsp_valid, paddr, pwdata} !== {1'b0, 32'h4, 32'hB1}) begin
      n_err++;
      $display("FAIL idle_hold: got rv=%b pa=%h pwd=%h, required 0 4 b1",
               rsp_valid, paddr, pwdata);
    end
  endtask

  task automatic test_read_wait;
    pready    = 1'b0;
    pslverr   = 1'b1;
    corrupt   = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h8;
    q.push_back({32'h3, 1'b0});
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    n_vec++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL rd_wait: got sel=%b en=%b rv=%b, required 1 1 0",
               psel, penable, rsp_valid);
    end
    tick;
    pready  = 1'b1;
    pslverr = 1'b0;
    corrupt = 1'b0;
    n_vec++;
    if ({penable, rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rd_access3: got en=%b rv=%b, required 1 0",
               penable, rsp_valid);
    end
    tick;
    n_vec++;
    if ({rsp_valid, psel, rsp_rdata} !== {2'b10, 32'h3}) begin
      n_err++;
      $display("FAIL rd_rsp_cycle5: got rv=%b sel=%b rd=%h, required 1 0 3",
               rsp_valid, psel, rsp_rdata);
    end
    tick;
  endtask

  task automatic test_slverr;
    pready    = 1'b1;
    pslverr   = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'hC;
    q.push_back({32'h4, 1'b1});
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    n_vec++;
    if ({rsp_valid, rsp_err} !== 2'b11) begin
      n_err++;
      $display("FAIL slverr: got rv=%b err=%b, required 1 1",
               rsp_valid, rsp_err);
    end
    pslverr   = 1'b0;
    req_valid = 1'b1;
    q.push_back({32'h4, 1'b0});
    tick;
    req_valid = 1'b0;
    n_vec++;
    if ({rsp_valid, rsp_err} !== 2'b01) begin
      n_err++;
      $display("FAIL err_hold: got rv=%b err=%b, required 0 1",
               rsp_valid, rsp_err);
    end
    tick;
    tick;
    n_vec++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      n_err++;
      $display("FAIL slverr_clear: got rv=%b err=%b, required 1 0",
               rsp_valid, rsp_err);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    pready    = 1'b1;
    pslverr   = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0;
    req_wdata = 32'h10;
    q.push_back({32'h0, 1'b0});
    tick;
    req_write = 1'b0;
    req_wdata = 32'h0;
    q.push_back({32'h10, 1'b0});
    tick;
    n_vec++;
    if ({pwrite, req_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_ignore: got pw=%b rr=%b, required 1 0",
               pwrite, req_ready);
    end
    tick;
    n_vec++;
    if ({rsp_valid, req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL b2b_cycle3: got rv=%b rr=%b, required 1 1",
               rsp_valid, req_ready);
    end
    tick;
    req_valid = 1'b0;
    n_vec++;
    if ({psel, penable, pwrite} !== 3'b100) begin
      n_err++;
      $display("FAIL b2b_setup2: got sel=%b en=%b pw=%b, required 1 0 0",
               psel, penable, pwrite);
    end
    tick;
    tick;
    n_vec++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h10}) begin
      n_err++;
      $display("FAIL b2b_cycle6: got rv=%b rd=%h, required 1 10",
               rsp_valid, rsp_rdata);
    end
    tick;
  endtask

  task automatic test_mid_reset;
    pready    = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    tick;
    req_valid = 1'b0;
    tick;
    preset_n = 1'b0;
    tick;
    n_vec++;
    if ({psel, penable, rsp_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL midrst: got sel=%b en=%b rv=%b, required 0 0 0",
               psel, penable, rsp_valid);
    end
    preset_n = 1'b1;
    pready   = 1'b1;
    tick;
    n_vec++;
    if ({req_ready, rsp_valid, psel} !== 3'b100) begin
      n_err++;
      $display("FAIL midrst_rel: got rr=%b rv=%b sel=%b, required 1 0 0",
               req_ready, rsp_valid, psel);
    end
    tick;
  endtask

  task automatic test_timeout;
    pready    = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h4;
`ifdef APB_TIMEOUT_EN
    q.push_back({32'h0, 1'b1});
    tick;
    req_valid = 1'b0;
    repeat (4) tick;
    n_vec++;
    if ({penable, rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL to_last_access: got en=%b rv=%b, required 1 0",
               penable, rsp_valid);
    end
    tick;
    n_vec++;
    if ({rsp_valid, rsp_err, psel, penable} !== 4'b1100) begin
      n_err++;
      $display("FAIL to_abort: got rv=%b err=%b sel=%b en=%b, required 1 1 0 0",
               rsp_valid, rsp_err, psel, penable);
    end
    tick;
    req_valid = 1'b1;
    req_addr  = 32'h8;
    q.push_back({32'h3, 1'b0});
    tick;
    req_valid = 1'b0;
    repeat (4) tick;
    pready = 1'b1;
    tick;
    n_vec++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      n_err++;
      $display("FAIL to_priority: got rv=%b err=%b, required 1 0",
               rsp_valid, rsp_err);
    end
    tick;
`else
    q.push_back({32'h2, 1'b0});
    tick;
    req_valid = 1'b0;
    repeat (20) tick;
    n_vec++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL long_wait: got sel=%b en=%b rv=%b, required 1 1 0",
               psel, penable, rsp_valid);
    end
    pready = 1'b1;
    tick;
    n_vec++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      n_err++;
      $display("FAIL long_wait_rsp: got rv=%b err=%b, required 1 0",
               rsp_valid, rsp_err);
    end
    tick;
`endif
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    preset_n  = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b1;
    pslverr   = 1'b0;
    corrupt   = 1'b0;
    test_reset;
    test_write_zero_wait;
    test_read_wait;
    test_slverr;
    test_back_to_back;
    test_mid_reset;
    test_timeout;
    tick;
    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
